// File: rtl/db_boot_loader_pkg.sv
// db_boot_loader_pkg: data-bus access codes and loader state encoding shared with the bus arbiter
package db_boot_loader_pkg;
  localparam logic [1:0] MEM_ACCESS_NONE = 2'b00;
  localparam logic [1:0] MEM_ACCESS_R    = 2'b01;
  localparam logic [1:0] MEM_ACCESS_W    = 2'b10;
  localparam logic [1:0] MEM_ACCESS_X    = 2'b11;
  localparam logic [2:0] LOADER_ST_IDLE  = 3'd0;
  localparam logic [2:0] LOADER_ST_WRITE = 3'd1;
  localparam logic [2:0] LOADER_ST_READ  = 3'd2;
  localparam logic [2:0] LOADER_ST_CHECK = 3'd3;
  localparam logic [2:0] LOADER_ST_DONE  = 3'd4;
  typedef enum logic [2:0] {
    ST_IDLE  = LOADER_ST_IDLE,
    ST_WRITE = LOADER_ST_WRITE,
    ST_READ  = LOADER_ST_READ,
    ST_CHECK = LOADER_ST_CHECK,
    ST_DONE  = LOADER_ST_DONE
  } loader_st_e;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/db_boot_loader.sv
// db_boot_loader: streams words onto the data bus from a base address, optionally reads them back
// to compare checksums, and holds the CPU in reset until the image is loaded.
module db_boot_loader
  import db_boot_loader_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter bit VERIFY = 1'b1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic [31:0]      db_addr,
  output logic [31:0]      db_dataOut,
  output logic [1:0]       db_accessType,
  input  logic             db_ready,
  input  logic [31:0]      db_dataIn,
  output logic             busy,
  output logic             done,
  output logic             verify_err,
  output logic [31:0]      checksum,
  output logic             cpu_hold
);
  loader_st_e state, nxt;
  logic [31:0] addr, base, wsum, rsum, rsum_nxt;
  logic [CNT_W-1:0] remaining, cnt;
  logic rd_pending, go, wr_xfer, rd_xfer, last;
  always_comb begin
    go            = start && (state == ST_IDLE || state == ST_DONE);
    wr_xfer       = state == ST_WRITE && s_valid && db_ready;
    rd_xfer       = state == ST_READ && db_ready;
    last          = remaining == CNT_W'(1);
    rsum_nxt      = rsum + (rd_pending ? db_dataIn : 32'd0);
    nxt           = go ? (word_count == '0 ? ST_DONE : ST_WRITE) :
                    (wr_xfer && last) ? (VERIFY ? ST_READ : ST_DONE) :
                    (rd_xfer && last) ? ST_CHECK :
                    state == ST_CHECK ? ST_DONE : state;
    db_accessType = (state == ST_WRITE && s_valid) ? MEM_ACCESS_W :
                    state == ST_READ ? MEM_ACCESS_R : MEM_ACCESS_NONE;
    db_addr       = addr;
    db_dataOut    = state == ST_WRITE ? s_data : 32'd0;
    s_ready       = wr_xfer;
    busy          = state == ST_WRITE || state == ST_READ || state == ST_CHECK;
    done          = state == ST_DONE;
    cpu_hold      = state != ST_DONE;
    checksum      = wsum;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state      <= ST_IDLE;
      addr       <= '0;
      base       <= '0;
      wsum       <= '0;
      rsum       <= '0;
      remaining  <= '0;
      cnt        <= '0;
      rd_pending <= 1'b0;
      verify_err <= 1'b0;
    end else begin
      state      <= nxt;
      rd_pending <= rd_xfer;
      if (go) begin
        addr       <= word_align(base_addr);
        base       <= word_align(base_addr);
        remaining  <= word_count;
        cnt        <= word_count;
        wsum       <= '0;
        rsum       <= '0;
        verify_err <= 1'b0;
      end else begin
        // The final write rewinds to the base so the read-back walks the same window.
        if (wr_xfer) begin
          wsum      <= wsum + s_data;
          addr      <= (last && VERIFY) ? base : addr + 32'd4;
          remaining <= last ? cnt : remaining - CNT_W'(1);
        end
        if (rd_xfer) begin
          addr      <= addr + 32'd4;
          remaining <= remaining - CNT_W'(1);
        end
        if (rd_pending) rsum <= rsum_nxt;
        if (state == ST_CHECK) verify_err <= rsum_nxt != wsum;
      end
    end
  end
endmodule

// File: tb/tb_db_boot_loader.sv
// tb_db_boot_loader: randomized scoreboard bench with a behavioural memory and source model
module tb_db_boot_loader;
  import db_boot_loader_pkg::*;
  localparam int CNT_W  = 16;
  localparam bit VERIFY = 1'b1;
  logic clk = 1'b0, res = 1'b0, start = 1'b0;
  logic [31:0] base_addr = '0, s_data = '0, db_dataIn = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic s_valid = 1'b0, db_ready = 1'b0;
  logic s_ready, busy, done, verify_err, cpu_hold;
  logic [31:0] db_addr, db_dataOut, checksum;
  logic [1:0] db_accessType;
  int checks = 0, failures = 0;
  logic [63:0] exp_w[$];
  logic [31:0] exp_r[$];
  logic [32:0] exp_res[$];
  logic [31:0] src_q[$];
  logic [31:0] mem [logic [31:0]];
  int rdy_pct = 100, gap_pct = 0, wr_cnt = 0, src_cnt = 0, acc_cnt = 0;
  bit stall_on = 0, gap_once = 0, corrupt_en = 0;
  logic [31:0] corrupt_addr = '0;
  always #5 clk = ~clk;
  db_boot_loader #(.CNT_W(CNT_W), .VERIFY(VERIFY)) dut (
    .clk(clk), .res(res), .start(start), .base_addr(base_addr), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .db_addr(db_addr),
    .db_dataOut(db_dataOut), .db_accessType(db_accessType), .db_ready(db_ready),
    .db_dataIn(db_dataIn), .busy(busy), .done(done), .verify_err(verify_err),
    .checksum(checksum), .cpu_hold(cpu_hold)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endtask
  // Bus responder, word source and scoreboard monitor: sample at negedge, drive just after posedge.
  initial begin
    bit acc_w, acc_r, cons, prev_pend, prev_done;
    logic [31:0] a, d, prev_a, prev_d;
    logic [1:0] prev_t;
    int stall, gap;
    logic [32:0] r;
    prev_pend = 0; prev_done = 0; stall = 0; gap = 0; prev_a = 0; prev_d = 0; prev_t = 0;
    forever begin
      @(negedge clk);
      acc_w = res && db_accessType == MEM_ACCESS_W && db_ready;
      acc_r = res && db_accessType == MEM_ACCESS_R && db_ready;
      cons  = res && s_valid && s_ready;
      a = db_addr;
      d = db_dataOut;
      if (res) begin
        chk("s_ready_rule", s_ready, db_accessType == MEM_ACCESS_W && db_ready);
        chk("access_legal", db_accessType == MEM_ACCESS_X || (!s_valid && db_accessType == MEM_ACCESS_W), 1'b0);
        if (prev_pend) begin
          chk("hold_type", db_accessType, prev_t);
          chk("hold_addr", a, prev_a);
          if (prev_t == MEM_ACCESS_W) chk("hold_data", d, prev_d);
        end
        if (acc_w) begin
          if (exp_w.size() == 0) fail_now("unexpected_write");
          else chk("write_addr_data", {a, d}, exp_w.pop_front());
        end
        if (acc_r) begin
          if (exp_r.size() == 0) fail_now("unexpected_read");
          else chk("read_addr", a, exp_r.pop_front());
        end
        if (done && !prev_done) begin
          if (exp_res.size() == 0) fail_now("unexpected_done");
          else begin
            r = exp_res.pop_front();
            chk("checksum", checksum, r[31:0]);
            chk("verify_err", verify_err, r[32]);
            chk("cpu_hold_released", cpu_hold, 1'b0);
          end
        end
        prev_pend = db_accessType != MEM_ACCESS_NONE && !db_ready;
        prev_t = db_accessType;
        prev_a = a;
        prev_d = d;
      end else prev_pend = 0;
      prev_done = res && done;
      if (acc_w || acc_r) acc_cnt++;
      @(posedge clk);
      #1;
      if (acc_w) begin
        mem[a] = (corrupt_en && a == corrupt_addr) ? 32'd6 : d;
        wr_cnt++;
        if (stall_on && wr_cnt == 1) stall = 2;
      end
      db_dataIn = (acc_r && mem.exists(a)) ? mem[a] : $urandom;
      db_ready = stall > 0 ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (stall > 0) stall--;
      if (cons) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        src_cnt++;
        gap = (gap_once && src_cnt == 1) ? 3 : ($urandom_range(99) < gap_pct ? $urandom_range(1, 3) : 0);
      end else if (gap > 0) gap--;
      s_valid = src_q.size() > 0 && gap == 0;
      s_data = s_valid ? src_q[0] : $urandom;
    end
  end
  task automatic expect_load(input logic [31:0] base, input logic [31:0] w[$], input bit corrupt,
                             input logic [31:0] caddr);
    logic [31:0] a, sum, rs;
    a = {base[31:2], 2'b00}; sum = 0; rs = 0;
    corrupt_en = corrupt; corrupt_addr = caddr; wr_cnt = 0; src_cnt = 0;
    foreach (w[i]) begin
      exp_w.push_back({a, w[i]});
      src_q.push_back(w[i]);
      sum += w[i];
      rs += (corrupt && a == caddr) ? 32'd6 : w[i];
      a += 32'd4;
    end
    a = {base[31:2], 2'b00};
    if (VERIFY) foreach (w[i]) begin
      exp_r.push_back(a);
      a += 32'd4;
    end
    exp_res.push_back({VERIFY && rs != sum, sum});
  endtask
  task automatic pulse_start(input logic [31:0] b, input logic [CNT_W-1:0] c);
    @(posedge clk); #1;
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = $urandom; word_count = CNT_W'($urandom);
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done_timeout");
    @(negedge clk);
  endtask
  task automatic run_load(input logic [31:0] base, input logic [31:0] w[$], input bit corrupt,
                          input logic [31:0] caddr, input bit poke);
    expect_load(base, w, corrupt, caddr);
    pulse_start(base, CNT_W'(w.size()));
    if (poke) pulse_start($urandom, '0);
    wait_done();
    chk("write_queue_drained", exp_w.size(), 0);
    chk("read_queue_drained", exp_r.size(), 0);
    chk("result_queue_drained", exp_res.size(), 0);
  endtask
  task automatic check_reset_vals();
    chk("rst_access", db_accessType, MEM_ACCESS_NONE);
    chk("rst_addr", db_addr, 0);
    chk("rst_dout", db_dataOut, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_verr", verify_err, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1);
  end
  initial begin
    logic [31:0] w[$];
    logic [31:0] b;
    int t0, n;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    res = 1'b1;
    t0 = acc_cnt;
    exp_res.push_back(33'd0);
    pulse_start(32'h40, '0);
    chk("zero_done_next_cycle", done, 1);
    chk("zero_not_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("zero_no_bus_access", acc_cnt - t0, 0);
    chk("zero_result_popped", exp_res.size(), 0);
    w = '{32'd4, 32'd5, 32'd9};
    run_load(32'h40, w, 1'b0, 32'h0, 1'b1);
    chk("mem_0x48", mem[32'h48], 9);
    run_load(32'h40, w, 1'b1, 32'h44, 1'b0);
    stall_on = 1;
    run_load(32'h40, w, 1'b0, 32'h0, 1'b0);
    stall_on = 0;
    gap_once = 1;
    run_load(32'h40, w, 1'b0, 32'h0, 1'b0);
    gap_once = 0;
    expect_load(32'h40, w, 1'b0, 32'h0);
    pulse_start(32'h40, CNT_W'(3));
    n = 0;
    while (!(db_accessType == MEM_ACCESS_W && db_addr == 32'h44) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) fail_now("second_write_timeout");
    #2 res = 1'b0;
    #1 check_reset_vals();
    exp_w.delete(); exp_r.delete(); exp_res.delete(); src_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    w = '{32'd7, 32'd8};
    run_load(32'h41, w, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      rdy_pct = $urandom_range(40, 100);
      gap_pct = $urandom_range(0, 30);
      b = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      w.delete();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) w.push_back(($urandom_range(1) == 0) ? 32'($urandom_range(9)) : $urandom);
      run_load(b, w, $urandom_range(3) == 0, {b[31:2], 2'b00} + 32'(4 * $urandom_range(n - 1)), 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
